// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 access codes, FSM states and
// legality/alignment helpers for RV32I loads and stores.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Unsigned variants exist only for loads.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return is_load;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'd1:    return addr_lo[0] == 1'b0;
            2'd2:    return addr_lo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module load_aligner
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] read_data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        read_data = rdata;
        case (funct3)
            F3_B:    read_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    read_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   read_data = {24'h0, shifted[7:0]};
            F3_HU:   read_data = {16'h0, shifted[15:0]};
            default: read_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage of the RV32I pipeline: issues a req/ack data-memory transaction,
// stalls until it completes, aligns load data and flags misaligned/illegal/timeout faults.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead_Mem_In,
    input  logic        memWrite_Mem_In,
    input  logic [2:0]  funct3_Mem_In,
    input  logic [31:0] aluOut_Mem_In,
    input  logic [31:0] writeD_Mem_In,
    input  logic [4:0]  rd_Mem_In,
    input  logic        regWrite_Mem_In,
    input  logic        memToRegWrite_Mem_In,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_Mem,
    output logic [31:0] readD_Mem_Out,
    output logic [31:0] aluOut_Mem_Out,
    output logic [4:0]  rd_Mem_Out,
    output logic        regWrite_Mem_Out,
    output logic        memToRegWrite_Mem_Out,
    output logic        fault_Mem_Out
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    mem_state_e    state, next_state;
    logic [CW-1:0] counter;
    logic [31:0]   hold;
    logic          err;

    logic        access, conflict, ok;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] aligned_data;

    assign access   = memRead_Mem_In ^ memWrite_Mem_In;
    assign conflict = memRead_Mem_In & memWrite_Mem_In;
    assign ok       = access && f3_legal(memRead_Mem_In, funct3_Mem_In)
                      && f3_aligned(funct3_Mem_In, aluOut_Mem_In[1:0]);

    // Store data is replicated across every lane so memory only needs the byte enables.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        be_next    = 4'b1111;
        wdata_next = writeD_Mem_In;
        case (funct3_Mem_In[1:0])
            2'd0: begin
                be_next    = 4'b0001 << aluOut_Mem_In[1:0];
                wdata_next = {4{writeD_Mem_In[7:0]}};
            end
            2'd1: begin
                be_next    = aluOut_Mem_In[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{writeD_Mem_In[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        next_state    = state;
        stall_Mem     = 1'b0;
        fault_Mem_Out = 1'b0;
        case (state)
            IDLE: begin
                if (ok) begin
                    next_state = REQ;
                    stall_Mem  = 1'b1;
                end else begin
                    fault_Mem_Out = access | conflict;
                end
            end
            REQ: begin
                stall_Mem = 1'b1;
                if (dmem_ack || counter == CNT_LAST) next_state = RESP;
            end
            RESP: begin
                fault_Mem_Out = err;
                next_state    = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    load_aligner u_load_aligner (
        .rdata     (hold),
        .addr_lo   (aluOut_Mem_In[1:0]),
        .funct3    (funct3_Mem_In),
        .read_data (aligned_data)
    );

    // MEM/WB only captures in RESP, so load data is exposed there and nowhere else.
    assign readD_Mem_Out         = (state == RESP && memRead_Mem_In) ? aligned_data : 32'h0;
    assign regWrite_Mem_Out      = regWrite_Mem_In & ~fault_Mem_Out;
    assign aluOut_Mem_Out        = aluOut_Mem_In;
    assign rd_Mem_Out            = rd_Mem_In;
    assign memToRegWrite_Mem_Out = memToRegWrite_Mem_In;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'h0;
            dmem_wdata <= 32'h0;
            counter    <= '0;
            hold       <= 32'h0;
            err        <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (ok) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= memWrite_Mem_In;
                        dmem_addr  <= {aluOut_Mem_In[31:2], 2'b00};
                        dmem_be    <= be_next;
                        dmem_wdata <= wdata_next;
                        counter    <= '0;
                        err        <= 1'b0;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        hold     <= dmem_rdata;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                    end else if (counter == CNT_LAST) begin
                        hold     <= 32'h0;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        err      <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus random loads/stores
// checked against a behavioural model of the MEM-stage rules.
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clk, rst;
    logic        mem_read, mem_write, reg_write, mem_to_reg;
    logic [2:0]  funct3;
    logic [31:0] alu_in, write_d;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall;
    logic [31:0] read_d, alu_out;
    logic [4:0]  rd_out;
    logic        reg_write_out, mem_to_reg_out, fault;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .memRead_Mem_In        (mem_read),
        .memWrite_Mem_In       (mem_write),
        .funct3_Mem_In         (funct3),
        .aluOut_Mem_In         (alu_in),
        .writeD_Mem_In         (write_d),
        .rd_Mem_In             (rd_in),
        .regWrite_Mem_In       (reg_write),
        .memToRegWrite_Mem_In  (mem_to_reg),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_be               (dmem_be),
        .dmem_wdata            (dmem_wdata),
        .dmem_ack              (dmem_ack),
        .dmem_rdata            (dmem_rdata),
        .stall_Mem             (stall),
        .readD_Mem_Out         (read_d),
        .aluOut_Mem_Out        (alu_out),
        .rd_Mem_Out            (rd_out),
        .regWrite_Mem_Out      (reg_write_out),
        .memToRegWrite_Mem_Out (mem_to_reg_out),
        .fault_Mem_Out         (fault)
    );

    typedef struct {
        logic [31:0] readd;
        logic        regw;
        logic        fault;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic        m2r;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int exp_writes = 0;
    logic instr_valid = 1'b0;
    logic quiet = 1'b0;
    logic prev_req = 1'b0;
    bus_t cur_bus;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference load semantics: shift the addressed lane down, then extend by arithmetic.
    function automatic logic [31:0] load_model(input logic [31:0] rdata, input logic [1:0] off,
                                               input logic [2:0] f3);
        int unsigned w;
        int v;
        w = rdata >> (8 * int'(off));
        case (f3)
            3'd0: begin v = int'(w % 256);   if (v >= 128)   v -= 256;   return 32'(v); end
            3'd1: begin v = int'(w % 65536); if (v >= 32768) v -= 65536; return 32'(v); end
            3'd2: return rdata;
            3'd4: return 32'(w % 256);
            3'd5: return 32'(w % 65536);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_ok(input logic rd_i, input logic wr_i, input logic [2:0] f3,
                                      input logic [31:0] a);
        logic legal, aligned;
        legal   = wr_i ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        aligned = (f3[1:0] == 2'd1) ? (a % 2 == 0) : (f3[1:0] == 2'd2) ? (a % 4 == 0) : 1'b1;
        return (rd_i != wr_i) && legal && aligned;
    endfunction

    // Drives one instruction into MEM, acts as the memory (ack after 'delay' REQ cycles,
    // never if delay < 0) and returns once MEM/WB would capture. Starts just after a posedge.
    task automatic run_instr(input logic rd_i, input logic wr_i, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                             input int delay, input logic regw, input logic m2r, input logic [4:0] rdi);
        resp_t r;
        bus_t  b;
        logic  ok, tmo, done;
        int    stall_cnt, req_cnt, exp_reqs;
        ok  = model_ok(rd_i, wr_i, f3, a);
        tmo = ok && delay < 0;
        exp_reqs = !ok ? 0 : (delay < 0 ? TO : delay + 1);
        r.fault = (rd_i && wr_i) || ((rd_i || wr_i) && !ok) || tmo;
        r.regw  = regw && !r.fault;
        r.readd = (ok && rd_i && !tmo) ? load_model(rdata, a[1:0], f3) : 32'h0;
        r.rd    = rdi;
        r.alu   = a;
        r.m2r   = m2r;
        resp_q.push_back(r);
        if (ok) begin
            b.we   = wr_i;
            b.addr = a & ~32'h3;
            case (f3[1:0])
                2'd0:    begin b.be = 4'(1 << a[1:0]);          b.wdata = (d & 32'hFF) * 32'h0101_0101; end
                2'd1:    begin b.be = a[1] ? 4'hC : 4'h3;        b.wdata = (d & 32'hFFFF) * 32'h0001_0001; end
                default: begin b.be = 4'hF;                      b.wdata = d; end
            endcase
            bus_q.push_back(b);
            if (wr_i && !tmo) exp_writes++;
        end
        mem_read = rd_i; mem_write = wr_i; funct3 = f3; alu_in = a; write_d = d;
        reg_write = regw; mem_to_reg = m2r; rd_in = rdi;
        instr_valid = 1'b1; quiet = 1'b0;
        stall_cnt = 0; req_cnt = 0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
            else stall_cnt++;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (!done && dmem_req) begin
                dmem_ack   = (req_cnt == delay);
                dmem_rdata = rdata;
                req_cnt++;
            end
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL stall_timeout: stall never released, got 1 expected 0");
        end
        check("stall_cycles", 32'(stall_cnt), 32'(ok ? exp_reqs + 1 : 0));
        check("req_cycles", 32'(req_cnt), 32'(exp_reqs));
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
        dmem_ack = 1'b0;
        instr_valid = 1'b0; quiet = 1'b1;
    endtask

    // Response monitor: compares whenever the stage releases a valid instruction.
    always @(negedge clk) begin
        if (!rst && instr_valid && !stall) begin
            if (resp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp_queue: got unexpected response expected none");
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                check("readD", read_d, e.readd);
                check("regWrite", 32'(reg_write_out), 32'(e.regw));
                check("fault", 32'(fault), 32'(e.fault));
                check("rd", 32'(rd_out), 32'(e.rd));
                check("aluOut", alu_out, e.alu);
                check("memToReg", 32'(mem_to_reg_out), 32'(e.m2r));
            end
        end
        if (!rst && quiet) begin
            check("idle_fault", 32'(fault), 32'h0);
            check("idle_stall", 32'(stall), 32'h0);
            check("idle_req", 32'(dmem_req), 32'h0);
        end
    end

    // Bus monitor: checks the request contents on its first cycle and stability afterwards.
    always @(negedge clk) begin
        if (dmem_req && !prev_req) begin
            if (bus_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL bus_queue: got unexpected dmem_req expected none");
            end else begin
                cur_bus = bus_q.pop_front();
                check("dmem_we", 32'(dmem_we), 32'(cur_bus.we));
                check("dmem_addr", dmem_addr, cur_bus.addr);
                if (cur_bus.we) begin
                    check("dmem_be", 32'(dmem_be), 32'(cur_bus.be));
                    check("dmem_wdata", dmem_wdata, cur_bus.wdata);
                end
            end
        end else if (dmem_req) begin
            check("req_addr_stable", dmem_addr, cur_bus.addr);
            check("req_we_stable", 32'(dmem_we), 32'(cur_bus.we));
        end
        if (dmem_req && dmem_ack && dmem_we) wr_count++;
        prev_req = dmem_req;
    end

    initial begin
        rst = 1'b1;
        mem_read = 0; mem_write = 0; funct3 = 0; alu_in = 0; write_d = 0;
        rd_in = 0; reg_write = 0; mem_to_reg = 0; dmem_ack = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(dmem_req), 32'h0);
        check("rst_we", 32'(dmem_we), 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_be", 32'(dmem_be), 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; quiet = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_instr(0, 1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0, 1, 0, 0, 5'd0);
        run_instr(1, 0, 3'd0, 32'h203, 32'h0, 32'h80FF_FF00, 0, 1, 1, 5'd7);
        run_instr(1, 0, 3'd4, 32'h203, 32'h0, 32'h80FF_FF00, 2, 1, 1, 5'd8);
        run_instr(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 0, 0, 0, 5'd0);
        run_instr(1, 0, 3'd2, 32'h101, 32'h0, 32'h1111_1111, 0, 1, 1, 5'd9);
        run_instr(1, 0, 3'd2, 32'h400, 32'h0, 32'hCAFE_F00D, -1, 1, 1, 5'd10);
        run_instr(1, 1, 3'd2, 32'h500, 32'h0, 32'h0, 0, 1, 0, 5'd11);
        run_instr(0, 0, 3'd0, 32'h0BAD_0001, 32'h0, 32'h0, 0, 1, 0, 5'd12);
        run_instr(1, 0, 3'd3, 32'h600, 32'h0, 32'h0, 0, 1, 1, 5'd13);
        run_instr(0, 1, 3'd4, 32'h600, 32'h55, 32'h0, 0, 0, 0, 5'd0);
        run_instr(1, 0, 3'd5, 32'h702, 32'h0, 32'h8001_7FFF, 0, 1, 1, 5'd14);
        run_instr(1, 0, 3'd1, 32'h702, 32'h0, 32'h8001_7FFF, 0, 1, 1, 5'd15);

        // Reset while a request is outstanding, with an ack arriving after reset.
        begin
            bus_t b;
            b.we = 1'b0; b.addr = 32'h300; b.be = 4'hF; b.wdata = 32'h0;
            bus_q.push_back(b);
            quiet = 1'b0;
            mem_read = 1'b1; funct3 = 3'd2; alu_in = 32'h300; reg_write = 1'b1; rd_in = 5'd3;
            for (int c = 0; c < 5 && !dmem_req; c++) begin
                @(posedge clk); #1;
            end
            check("rst_test_req_seen", 32'(dmem_req), 32'h1);
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; mem_read = 1'b0; reg_write = 1'b0;
            dmem_ack = 1'b1; dmem_rdata = $urandom;
            @(negedge clk);
            check("rst_abort_req", 32'(dmem_req), 32'h0);
            check("rst_abort_stall", 32'(stall), 32'h0);
            check("rst_abort_fault", 32'(fault), 32'h0);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            @(negedge clk);
            check("late_ack_req", 32'(dmem_req), 32'h0);
            check("late_ack_fault", 32'(fault), 32'h0);
            check("late_ack_readD", read_d, 32'h0);
            @(posedge clk); #1;
            quiet = 1'b1;
        end

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            logic rd_i, wr_i;
            logic [31:0] a;
            int sel, delay;
            sel  = int'($urandom_range(0, 19));
            rd_i = (sel < 9) || sel == 19;
            wr_i = (sel >= 9 && sel < 17) || sel == 19;
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            delay = ($urandom_range(0, 24) == 0) ? -1 : int'($urandom_range(0, 5));
            run_instr(rd_i, wr_i, 3'($urandom_range(0, 7)), a, $urandom, $urandom, delay,
                      1'($urandom), 1'($urandom), 5'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("write_count", 32'(wr_count), 32'(exp_writes));
        check("resp_q_drained", 32'(resp_q.size()), 32'h0);
        check("bus_q_drained", 32'(bus_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
